add_sched: RTL and testbench

Sequential scheduler that shares one 64-bit ripple-carry adder (the ALU adder instance, carry-in fixed at 0) between two requesters. It supports both add and subtract. Subtract is built from two adder passes: first −b = ~b + 1, then a + (−b). Results carry registered Y86-64 condition flags (ZF, SF, OF). It sits in the ALU next to the adder and lets execute-stage ops and auxiliary address arithmetic share one adder.

---
 rtl/add_sched.sv | 151 +++++++++++++++
 tb/tb_add_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// Two-requester scheduler sharing one 64-bit adder for add/sub.
// Subtract negates b in a first adder pass, then adds.
module add_sched #(
  parameter bit RR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_a,
  input  logic [63:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_a,
  input  logic [63:0] req1_b,
  input  logic        req1_sub,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [63:0] resp_sum,
  output logic        resp_zf,
  output logic        resp_sf,
  output logic        resp_of
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NEG,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        r_sub;
  logic        r_id;
  logic        r_b63;
  logic        r_last;
  logic [63:0] r_sum;
  logic        r_resp_id;
  logic        r_zf;
  logic        r_sf;
  logic        r_of;

  logic        w_idle;
  logic        w_g1;
  logic        w_acc;
  logic [63:0] w_op_a;
  logic [63:0] w_op_b;
  logic [63:0] w_add;
  logic        w_of;

  // With both valid in RR mode, favour the one not granted last.
  always_comb begin
    if (RR)
      w_g1 = req1_valid && (!req0_valid || !r_last);
    else
      w_g1 = req1_valid && !req0_valid;
  end

  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign w_acc      = w_idle && (req0_valid || req1_valid);
  assign req0_ready = w_idle && req0_valid && !w_g1;
  assign req1_ready = w_idle && w_g1;

  // Adder operands come only from internal registers.
  always_comb begin
    w_op_a = r_a;
    w_op_b = r_b;
    unique case (1'b1)
      (r_state == S_NEG): begin
        w_op_a = ~r_b;
        w_op_b = 64'd1;
      end
      default: begin
        w_op_a = r_a;
        w_op_b = r_b;
      end
    endcase
  end

  assign w_add = w_op_a + w_op_b;

  always_comb begin
    if (r_sub)
      w_of = (r_a[63] != r_b63) && (w_add[63] != r_a[63]);
    else
      w_of = (r_a[63] == r_b63) && (w_add[63] != r_a[63]);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) begin
        if (w_g1) w_next = req1_sub ? S_NEG : S_ADD;
        else      w_next = req0_sub ? S_NEG : S_ADD;
      end
      S_NEG:   w_next = S_ADD;
      S_ADD:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sub     <= 1'b0;
      r_id      <= 1'b0;
      r_b63     <= 1'b0;
      r_last    <= 1'b1;
      r_sum     <= '0;
      r_resp_id <= 1'b0;
      r_zf      <= 1'b0;
      r_sf      <= 1'b0;
      r_of      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a    <= w_g1 ? req1_a : req0_a;
        r_b    <= w_g1 ? req1_b : req0_b;
        r_sub  <= w_g1 ? req1_sub : req0_sub;
        r_b63  <= w_g1 ? req1_b[63] : req0_b[63];
        r_id   <= w_g1;
        r_last <= w_g1;
      end
      if (r_state == S_NEG)
        r_b <= w_add;
      if (r_state == S_ADD) begin
        r_sum     <= w_add;
        r_resp_id <= r_id;
        r_zf      <= (w_add == 64'd0);
        r_sf      <= w_add[63];
        r_of      <= w_of;
      end
    end
  end

  assign resp_valid = (r_state == S_DONE) && !rst;
  assign resp_id    = r_resp_id;
  assign resp_sum   = r_sum;
  assign resp_zf    = r_zf;
  assign resp_sf    = r_sf;
  assign resp_of    = r_of;

endmodule

// File: tb/tb_add_sched.sv
// Directed bench for add_sched: add/sub results, flags,
// latency, arbitration in both modes and reset mid-op.
module tb_add_sched;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_sub, req1_sub;

  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id;
  logic [63:0] resp_sum;
  logic        resp_zf, resp_sf, resp_of;

  logic        fp_r0, fp_r1;
  logic        fp_rv, fp_id;
  logic [63:0] fp_sum;
  logic        fp_zf, fp_sf, fp_of;

  int n_chk = 0;
  int n_err = 0;

  add_sched #(.RR(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_zf(resp_zf),
    .resp_sf(resp_sf), .resp_of(resp_of)
  );

  add_sched #(.RR(1'b0)) u_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_r0),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(fp_r1),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .resp_valid(fp_rv), .resp_id(fp_id),
    .resp_sum(fp_sum), .resp_zf(fp_zf),
    .resp_sf(fp_sf), .resp_of(fp_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic id,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic sub, input logic [63:0] es,
                       input logic ez, input logic esf,
                       input logic eo, input int elat);
    logic acc;
    int   lat;
    @(posedge clk); #1;
    if (!id) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        acc = 1'b1;
        break;
      end
    end
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_id"}, 64'(resp_id), 64'(id));
    chk({tag, "_sum"}, resp_sum, es);
    chk({tag, "_flags"}, 64'({resp_zf, resp_sf, resp_of}),
        64'({ez, esf, eo}));
  endtask

  initial begin
    int   rr_acc, fp_acc, fp_r1n, nresp;
    logic exp_g, exp_r;
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_rdy", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_rv", 64'(resp_valid), 64'd0);
    chk("rst_sum", resp_sum, 64'd0);
    chk("rst_fl", 64'({resp_id, resp_zf, resp_sf, resp_of}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;

    do_op("add", 1'b0, 64'd5, 64'd7, 1'b0, 64'd12,
          1'b0, 1'b0, 1'b0, 2);
    do_op("sub_neg", 1'b1, 64'd3, 64'd5, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 3);
    do_op("sub_zero", 1'b1, 64'd9, 64'd9, 1'b1, 64'd0,
          1'b1, 1'b0, 1'b0, 3);
    do_op("add_ovf", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 2);
    do_op("sub_min", 1'b0, 64'd0, 64'h8000_0000_0000_0000, 1'b1,
          64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 3);
    do_op("sub_m1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 3);

    // operands changed while in flight must not leak in
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd23;
    req0_sub = 1'b0;
    @(negedge clk);
    chk("hold_acc", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_a = 64'd999;
    @(negedge clk);
    chk("hold_rdy1", 64'({req0_ready, resp_valid}), 64'd0);
    @(negedge clk);
    chk("hold_rdy2", 64'({req0_ready, resp_valid}), 64'b01);
    chk("hold_sum", resp_sum, 64'd123);
    @(posedge clk); #1;
    req0_valid = 1'b0;

    // both requesters valid continuously from reset
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2;
    req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 64'd10; req1_b = 64'd20;
    req1_sub = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_acc = 0; fp_acc = 0; fp_r1n = 0;
    exp_g = 1'b0; exp_r = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("rr_grant", 64'(req1_ready), 64'(exp_g));
        exp_g = ~exp_g;
        rr_acc++;
      end
      if (resp_valid) begin
        chk("rr_id", 64'(resp_id), 64'(exp_r));
        chk("rr_sum", resp_sum, exp_r ? 64'd30 : 64'd3);
        exp_r = ~exp_r;
      end
      if (fp_r0) fp_acc++;
      if (fp_r1) fp_r1n++;
      if (fp_rv) chk("fp_id", 64'(fp_id), 64'd0);
    end
    chk("rr_nacc", 64'(rr_acc), 64'd8);
    chk("fp_nacc", 64'(fp_acc), 64'd8);
    chk("fp_r1", 64'(fp_r1n), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (5) @(posedge clk);

    // reset during NEG of a subtract
    #1;
    req0_valid = 1'b1; req0_a = 64'd50; req0_b = 64'd8;
    req0_sub = 1'b1;
    @(negedge clk);
    chk("mid_acc", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    req0_a = 64'd2; req0_b = 64'd3; req0_sub = 1'b0;
    @(negedge clk);
    chk("mid_rst", 64'({req0_ready, resp_valid}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_sum", resp_sum, 64'd0);
    chk("mid_fl", 64'({resp_id, resp_zf, resp_sf, resp_of}), 64'd0);
    chk("mid_rdy", 64'({req0_ready, resp_valid}), 64'b10);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    nresp = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        nresp++;
        chk("mid_lat", 64'(k), 64'd2);
        chk("mid_res", resp_sum, 64'd5);
      end
    end
    chk("mid_nresp", 64'(nresp), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
